// File: rtl/apb_csr_bridge.sv
// APB3/APB4 slave that turns each transfer into one single-cycle CSR strobe.
// Every output is registered; reads wait RD_LATENCY cycles for the CSR map's data.
module apb_csr_bridge #(
    parameter int unsigned APB_ADDR_W = 12,
    parameter int unsigned CSR_ADDR_W = 8,
    parameter int unsigned NUM_REGS   = 2,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                  reg_clk_i,
    input  logic                  reg_rst_n_i,
    input  logic                  psel_i,
    input  logic                  penable_i,
    input  logic                  pwrite_i,
    input  logic [APB_ADDR_W-1:0] paddr_i,
    input  logic [31:0]           pwdata_i,
    input  logic [3:0]            pstrb_i,
    output logic                  pready_o,
    output logic [31:0]           prdata_o,
    output logic                  pslverr_o,
    output logic [31:0]           reg_wr_data_o,
    output logic                  reg_wr_en_o,
    output logic                  reg_rd_en_o,
    output logic [CSR_ADDR_W-1:0] reg_addr_o,
    input  logic [31:0]           reg_rd_data_i,
    output logic [15:0]           err_cnt_o
);

    typedef enum logic [2:0] {IDLE, WR, RD_WAIT, RD_CAP, RESP} state_t;

    localparam int unsigned IDX_W    = APB_ADDR_W - 2;
    localparam logic [1:0]  LAT_LOAD = 2'(RD_LATENCY - 1);

    state_t                r_state, w_state_nxt;
    logic [1:0]            r_lat_cnt, w_lat_cnt_nxt;
    logic                  r_pready, w_pready_nxt;
    logic                  r_pslverr, w_pslverr_nxt;
    logic                  r_wr_en, w_wr_en_nxt;
    logic                  r_rd_en, w_rd_en_nxt;
    logic [31:0]           r_prdata, w_prdata_nxt;
    logic [31:0]           r_wr_data, w_wr_data_nxt;
    logic [CSR_ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [15:0]           r_err_cnt, w_err_cnt_nxt;

    logic [IDX_W-1:0]      w_idx;
    logic                  w_setup;
    logic                  w_illegal;

    assign w_idx     = paddr_i[APB_ADDR_W-1:2];
    assign w_setup   = psel_i && !penable_i;
    assign w_illegal = (paddr_i[1:0] != 2'b00)
                    || (32'(w_idx) >= NUM_REGS)
                    || (pwrite_i && (pstrb_i != 4'hF));

    // Next-state and next-output logic; outputs are registered so each value
    // below appears on the port in the cycle after the state that computes it.
    always_comb begin
        w_state_nxt   = r_state;
        w_lat_cnt_nxt = r_lat_cnt;
        w_pready_nxt  = 1'b0;
        w_pslverr_nxt = 1'b0;
        w_wr_en_nxt   = 1'b0;
        w_rd_en_nxt   = 1'b0;
        w_prdata_nxt  = r_prdata;
        w_wr_data_nxt = r_wr_data;
        w_addr_nxt    = r_addr;
        w_err_cnt_nxt = r_err_cnt;

        case (r_state)
            IDLE: begin
                if (w_setup) begin
                    if (w_illegal) begin
                        w_state_nxt   = RESP;
                        w_pready_nxt  = 1'b1;
                        w_pslverr_nxt = 1'b1;
                        w_prdata_nxt  = 32'h0;
                        w_err_cnt_nxt = (r_err_cnt == 16'hFFFF) ? r_err_cnt : r_err_cnt + 16'd1;
                    end else if (pwrite_i) begin
                        w_state_nxt   = WR;
                        w_wr_en_nxt   = 1'b1;
                        w_pready_nxt  = 1'b1;
                        w_addr_nxt    = w_idx[CSR_ADDR_W-1:0];
                        w_wr_data_nxt = pwdata_i;
                    end else begin
                        w_state_nxt   = RD_WAIT;
                        w_rd_en_nxt   = 1'b1;
                        w_addr_nxt    = w_idx[CSR_ADDR_W-1:0];
                        w_lat_cnt_nxt = LAT_LOAD;
                    end
                end
            end
            WR: begin
                w_state_nxt = IDLE;
            end
            RD_WAIT: begin
                if (r_lat_cnt != 2'd0) begin
                    w_lat_cnt_nxt = r_lat_cnt - 2'd1;
                end else begin
                    w_state_nxt = RD_CAP;
                end
            end
            RD_CAP: begin
                w_state_nxt  = RESP;
                w_prdata_nxt = reg_rd_data_i;
                w_pready_nxt = 1'b1;
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge reg_clk_i or negedge reg_rst_n_i) begin
        if (!reg_rst_n_i) begin
            r_state   <= IDLE;
            r_lat_cnt <= 2'd0;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_prdata  <= 32'h0;
            r_wr_data <= 32'h0;
            r_addr    <= '0;
            r_err_cnt <= 16'h0;
        end else begin
            r_state   <= w_state_nxt;
            r_lat_cnt <= w_lat_cnt_nxt;
            r_pready  <= w_pready_nxt;
            r_pslverr <= w_pslverr_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_rd_en   <= w_rd_en_nxt;
            r_prdata  <= w_prdata_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_addr    <= w_addr_nxt;
            r_err_cnt <= w_err_cnt_nxt;
        end
    end

    assign pready_o      = r_pready;
    assign pslverr_o     = r_pslverr;
    assign prdata_o      = r_prdata;
    assign reg_wr_en_o   = r_wr_en;
    assign reg_rd_en_o   = r_rd_en;
    assign reg_wr_data_o = r_wr_data;
    assign reg_addr_o    = r_addr;
    assign err_cnt_o     = r_err_cnt;

endmodule

// File: tb/tb_apb_csr_bridge.sv
// Bench for apb_csr_bridge: two instances (read latency 1 and 4) checked every
// cycle against a transaction-level timeline model, plus literal expectations.
module tb_apb_csr_bridge;

    logic        clk = 1'b0;
    logic        rstN    [2];
    logic        psel    [2];
    logic        penable [2];
    logic        pwrite  [2];
    logic [11:0] paddr   [2];
    logic [31:0] pwdata  [2];
    logic [3:0]  pstrb   [2];
    logic        pready  [2];
    logic [31:0] prdata  [2];
    logic        pslverr [2];
    logic [31:0] wrData  [2];
    logic        wrEn    [2];
    logic        rdEn    [2];
    logic [7:0]  regAddr [2];
    logic [31:0] rdData  [2];
    logic [15:0] errCnt  [2];

    int cyc = 0;
    int nChecks = 0;
    int nFails = 0;

    // One scheduled model event: what the bridge must show in a given cycle.
    typedef struct {
        int          dut;
        int          cyc;
        bit          pready;
        bit          pslverr;
        bit          wr;
        bit          rd;
        bit          setAddr;
        logic [7:0]  addr;
        bit          setWdata;
        logic [31:0] wdata;
        bit          setPrdata;
        logic [31:0] prdata;
        bit          incErr;
    } ev_t;

    ev_t         evq[$];
    logic [7:0]  mAddr  [2];
    logic [31:0] mWdata [2];
    logic [31:0] mPrdata[2];
    logic [15:0] mErr   [2];

    always #5 clk = ~clk;

    apb_csr_bridge #(.APB_ADDR_W(12), .CSR_ADDR_W(8), .NUM_REGS(2), .RD_LATENCY(1)) dut0 (
        .reg_clk_i(clk), .reg_rst_n_i(rstN[0]),
        .psel_i(psel[0]), .penable_i(penable[0]), .pwrite_i(pwrite[0]),
        .paddr_i(paddr[0]), .pwdata_i(pwdata[0]), .pstrb_i(pstrb[0]),
        .pready_o(pready[0]), .prdata_o(prdata[0]), .pslverr_o(pslverr[0]),
        .reg_wr_data_o(wrData[0]), .reg_wr_en_o(wrEn[0]), .reg_rd_en_o(rdEn[0]),
        .reg_addr_o(regAddr[0]), .reg_rd_data_i(rdData[0]), .err_cnt_o(errCnt[0])
    );

    apb_csr_bridge #(.APB_ADDR_W(12), .CSR_ADDR_W(8), .NUM_REGS(2), .RD_LATENCY(4)) dut1 (
        .reg_clk_i(clk), .reg_rst_n_i(rstN[1]),
        .psel_i(psel[1]), .penable_i(penable[1]), .pwrite_i(pwrite[1]),
        .paddr_i(paddr[1]), .pwdata_i(pwdata[1]), .pstrb_i(pstrb[1]),
        .pready_o(pready[1]), .prdata_o(prdata[1]), .pslverr_o(pslverr[1]),
        .reg_wr_data_o(wrData[1]), .reg_wr_en_o(wrEn[1]), .reg_rd_en_o(rdEn[1]),
        .reg_addr_o(regAddr[1]), .reg_rd_data_i(rdData[1]), .err_cnt_o(errCnt[1])
    );

    function automatic int latOf(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic ev_t newEv(input int d, input int c);
        ev_t e;
        e = '{default: 0};
        e.dut = d;
        e.cyc = c;
        return e;
    endfunction

    // Schedule everything a transfer set up in cycle s must produce.
    task automatic predict(input int d, input int s, input logic wr, input logic [11:0] a,
                           input logic [31:0] wd, input logic [3:0] st, input logic [31:0] rdv);
        int  idx;
        bit  bad;
        ev_t e;
        idx = int'(a) / 4;
        bad = (int'(a) % 4 != 0) || (idx >= 2) || (wr && st != 4'hF);
        e = newEv(d, s + 1);
        if (bad) begin
            e.pready = 1; e.pslverr = 1; e.setPrdata = 1; e.prdata = 32'h0; e.incErr = 1;
            evq.push_back(e);
        end else if (wr) begin
            e.pready = 1; e.wr = 1; e.setAddr = 1; e.addr = 8'(idx); e.setWdata = 1; e.wdata = wd;
            evq.push_back(e);
        end else begin
            e.rd = 1; e.setAddr = 1; e.addr = 8'(idx);
            evq.push_back(e);
            e = newEv(d, s + latOf(d) + 2);
            e.pready = 1; e.setPrdata = 1; e.prdata = rdv;
            evq.push_back(e);
        end
    endtask

    task automatic modelReset(input int d);
        for (int i = evq.size() - 1; i >= 0; i--) begin
            if (evq[i].dut == d) evq.delete(i);
        end
        mAddr[d] = 8'h0; mWdata[d] = 32'h0; mPrdata[d] = 32'h0; mErr[d] = 16'h0;
    endtask

    // One full APB transfer; reports cycles from setup to pready and the outputs seen then.
    task automatic applyStimulus(input int d, input logic wr, input logic [11:0] a, input logic [31:0] wd,
                                 input logic [3:0] st, input logic [31:0] rdv, input bit violate,
                                 output int lat, output logic [31:0] prAt, output logic errAt,
                                 output logic [15:0] cntAt, output logic [7:0] addrAt,
                                 output logic [31:0] wdAt, output logic wrAt);
        int s;
        bit done;
        lat = -1; prAt = 32'h0; errAt = 1'b0; cntAt = 16'h0; addrAt = 8'h0; wdAt = 32'h0; wrAt = 1'b0;
        @(negedge clk);
        s = cyc;
        psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = a; pwdata[d] = wd; pstrb[d] = st;
        rdData[d] = ~rdv;
        predict(d, s, wr, a, wd, st, rdv);
        done = 0;
        for (int k = 1; k <= 20 && !done; k++) begin
            @(negedge clk);
            if (violate) begin
                if (k == 2) begin
                    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = 1'b1; paddr[d] = 12'h000;
                    pwdata[d] = 32'hBAD0_BAD0; pstrb[d] = 4'hF;
                end else begin
                    psel[d] = 1'b0; penable[d] = 1'b0;
                end
            end else begin
                penable[d] = 1'b1;
            end
            rdData[d] = (k == latOf(d) + 1) ? rdv : ~rdv;
            if (pready[d]) begin
                done = 1; lat = k; prAt = prdata[d]; errAt = pslverr[d]; cntAt = errCnt[d];
                addrAt = regAddr[d]; wdAt = wrData[d]; wrAt = wrEn[d];
            end
        end
        checkOutput($sformatf("dut%0d pready within bound", d), 32'(done), 32'd1);
    endtask

    task automatic applyIdle(input int d, input int n);
        repeat (n) begin
            @(negedge clk);
            psel[d] = 1'b0; penable[d] = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Compare process: every cycle, both instances against the model timeline.
    initial begin
        bit ePr, eErr, eWr, eRd;
        forever begin
            @(posedge clk);
            #2;
            for (int d = 0; d < 2; d++) begin
                ePr = 0; eErr = 0; eWr = 0; eRd = 0;
                for (int i = evq.size() - 1; i >= 0; i--) begin
                    if (evq[i].dut == d && evq[i].cyc == cyc) begin
                        ePr  = ePr  | evq[i].pready;
                        eErr = eErr | evq[i].pslverr;
                        eWr  = eWr  | evq[i].wr;
                        eRd  = eRd  | evq[i].rd;
                        if (evq[i].setAddr)   mAddr[d]   = evq[i].addr;
                        if (evq[i].setWdata)  mWdata[d]  = evq[i].wdata;
                        if (evq[i].setPrdata) mPrdata[d] = evq[i].prdata;
                        if (evq[i].incErr && mErr[d] != 16'hFFFF) mErr[d] = mErr[d] + 16'd1;
                        evq.delete(i);
                    end
                end
                checkOutput($sformatf("dut%0d pready", d),   32'(pready[d]),  32'(ePr));
                checkOutput($sformatf("dut%0d pslverr", d),  32'(pslverr[d]), 32'(eErr));
                checkOutput($sformatf("dut%0d reg_wr_en", d), 32'(wrEn[d]),   32'(eWr));
                checkOutput($sformatf("dut%0d reg_rd_en", d), 32'(rdEn[d]),   32'(eRd));
                checkOutput($sformatf("dut%0d reg_addr", d), 32'(regAddr[d]), 32'(mAddr[d]));
                checkOutput($sformatf("dut%0d reg_wr_data", d), wrData[d], mWdata[d]);
                checkOutput($sformatf("dut%0d prdata", d),   prdata[d], mPrdata[d]);
                checkOutput($sformatf("dut%0d err_cnt", d),  32'(errCnt[d]), 32'(mErr[d]));
            end
        end
    end

    initial begin
        #2_000_000;
        nChecks++;
        nFails++;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          lat;
        logic [31:0] prAt;
        logic        errAt;
        logic [15:0] cntAt;
        logic [7:0]  addrAt;
        logic [31:0] wdAt;
        logic        wrAt;
        int          s;

        for (int d = 0; d < 2; d++) begin
            rstN[d] = 1'b1; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
            paddr[d] = 12'h0; pwdata[d] = 32'h0; pstrb[d] = 4'h0; rdData[d] = 32'h0;
            modelReset(d);
        end
        #1;
        rstN[0] = 1'b0;
        rstN[1] = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset pready", 32'(pready[0]), 32'd0);
        checkOutput("reset err_cnt", 32'(errCnt[0]), 32'd0);
        rstN[0] = 1'b1;
        rstN[1] = 1'b1;
        applyIdle(0, 2);

        $display("[TB] writes on latency-1 instance");
        applyStimulus(0, 1'b1, 12'h004, 32'h0000_8015, 4'hF, 32'h0, 1'b0, lat, prAt, errAt, cntAt, addrAt, wdAt, wrAt);
        checkOutput("wr1 latency", 32'(lat), 32'd1);
        checkOutput("wr1 reg_wr_en", 32'(wrAt), 32'd1);
        checkOutput("wr1 reg_addr", 32'(addrAt), 32'd1);
        checkOutput("wr1 reg_wr_data", wdAt, 32'h0000_8015);
        checkOutput("wr1 pslverr", 32'(errAt), 32'd0);
        applyStimulus(0, 1'b1, 12'h000, 32'hA5A5_0001, 4'hF, 32'h0, 1'b0, lat, prAt, errAt, cntAt, addrAt, wdAt, wrAt);
        checkOutput("wr2 reg_addr", 32'(addrAt), 32'd0);
        checkOutput("wr2 reg_wr_data", wdAt, 32'hA5A5_0001);

        $display("[TB] read right after a write");
        applyStimulus(0, 1'b0, 12'h000, 32'h0, 4'hF, 32'h0020_0005, 1'b0, lat, prAt, errAt, cntAt, addrAt, wdAt, wrAt);
        checkOutput("rd1 latency", 32'(lat), 32'd3);
        checkOutput("rd1 prdata", prAt, 32'h0020_0005);
        checkOutput("rd1 pslverr", 32'(errAt), 32'd0);
        applyIdle(0, 2);

        $display("[TB] illegal requests");
        applyStimulus(0, 1'b0, 12'h002, 32'h0, 4'hF, 32'h0, 1'b0, lat, prAt, errAt, cntAt, addrAt, wdAt, wrAt);
        checkOutput("err1 latency", 32'(lat), 32'd1);
        checkOutput("err1 pslverr", 32'(errAt), 32'd1);
        checkOutput("err1 prdata", prAt, 32'h0);
        checkOutput("err1 err_cnt", 32'(cntAt), 32'd1);
        applyStimulus(0, 1'b1, 12'h008, 32'h1, 4'hF, 32'h0, 1'b0, lat, prAt, errAt, cntAt, addrAt, wdAt, wrAt);
        checkOutput("err2 pslverr", 32'(errAt), 32'd1);
        checkOutput("err2 err_cnt", 32'(cntAt), 32'd2);
        applyStimulus(0, 1'b1, 12'h004, 32'h2, 4'h3, 32'h0, 1'b0, lat, prAt, errAt, cntAt, addrAt, wdAt, wrAt);
        checkOutput("err3 pslverr", 32'(errAt), 32'd1);
        checkOutput("err3 err_cnt", 32'(cntAt), 32'd3);
        checkOutput("err3 reg_wr_data held", wdAt, 32'hA5A5_0001);

        $display("[TB] read ignores pstrb");
        applyStimulus(0, 1'b0, 12'h004, 32'h0, 4'h0, 32'h1234_5678, 1'b0, lat, prAt, errAt, cntAt, addrAt, wdAt, wrAt);
        checkOutput("rd2 latency", 32'(lat), 32'd3);
        checkOutput("rd2 prdata", prAt, 32'h1234_5678);
        checkOutput("rd2 reg_addr", 32'(addrAt), 32'd1);

        $display("[TB] psel dropped mid-read, stray setup while busy");
        applyStimulus(0, 1'b0, 12'h000, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b1, lat, prAt, errAt, cntAt, addrAt, wdAt, wrAt);
        checkOutput("viol latency", 32'(lat), 32'd3);
        checkOutput("viol prdata", prAt, 32'hCAFE_F00D);
        applyIdle(0, 4);

        // Walking 65534 illegal transfers would take ~131k cycles, so the counter is preloaded.
        $display("[TB] error counter saturation");
        @(negedge clk);
        #1;
        force dut0.r_err_cnt = 16'hFFFE;
        mErr[0] = 16'hFFFE;
        @(negedge clk);
        #1;
        release dut0.r_err_cnt;
        applyStimulus(0, 1'b0, 12'h00C, 32'h0, 4'hF, 32'h0, 1'b0, lat, prAt, errAt, cntAt, addrAt, wdAt, wrAt);
        checkOutput("sat1 err_cnt", 32'(cntAt), 32'h0000_FFFF);
        applyStimulus(0, 1'b0, 12'h003, 32'h0, 4'hF, 32'h0, 1'b0, lat, prAt, errAt, cntAt, addrAt, wdAt, wrAt);
        checkOutput("sat2 err_cnt", 32'(cntAt), 32'h0000_FFFF);
        checkOutput("sat2 pslverr", 32'(errAt), 32'd1);
        applyIdle(0, 2);

        $display("[TB] latency-4 instance, back-to-back reads");
        applyStimulus(1, 1'b1, 12'h00C, 32'h0, 4'hF, 32'h0, 1'b0, lat, prAt, errAt, cntAt, addrAt, wdAt, wrAt);
        checkOutput("l4 err err_cnt", 32'(cntAt), 32'd1);
        applyStimulus(1, 1'b0, 12'h000, 32'h0, 4'hF, 32'h1111_0000, 1'b0, lat, prAt, errAt, cntAt, addrAt, wdAt, wrAt);
        checkOutput("l4 rd1 latency", 32'(lat), 32'd6);
        checkOutput("l4 rd1 prdata", prAt, 32'h1111_0000);
        applyStimulus(1, 1'b0, 12'h004, 32'h0, 4'hF, 32'h2222_0001, 1'b0, lat, prAt, errAt, cntAt, addrAt, wdAt, wrAt);
        checkOutput("l4 rd2 latency", 32'(lat), 32'd6);
        checkOutput("l4 rd2 prdata", prAt, 32'h2222_0001);
        checkOutput("l4 rd2 reg_addr", 32'(addrAt), 32'd1);

        $display("[TB] reset asserted during RD_WAIT");
        @(negedge clk);
        s = cyc;
        psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b0; paddr[1] = 12'h004;
        predict(1, s, 1'b0, 12'h004, 32'h0, 4'hF, 32'h3333_3333);
        @(negedge clk);
        penable[1] = 1'b1;
        @(negedge clk);
        #1;
        rstN[1] = 1'b0;
        psel[1] = 1'b0; penable[1] = 1'b0;
        modelReset(1);
        #1;
        checkOutput("async rst pready", 32'(pready[1]), 32'd0);
        checkOutput("async rst pslverr", 32'(pslverr[1]), 32'd0);
        checkOutput("async rst reg_wr_en", 32'(wrEn[1]), 32'd0);
        checkOutput("async rst reg_rd_en", 32'(rdEn[1]), 32'd0);
        checkOutput("async rst prdata", prdata[1], 32'h0);
        checkOutput("async rst reg_addr", 32'(regAddr[1]), 32'd0);
        checkOutput("async rst err_cnt", 32'(errCnt[1]), 32'd0);
        repeat (2) @(negedge clk);
        rstN[1] = 1'b1;
        applyIdle(1, 10);
        checkOutput("post rst err_cnt", 32'(errCnt[1]), 32'd0);
        applyStimulus(1, 1'b1, 12'h004, 32'h0BAD_CAFE, 4'hF, 32'h0, 1'b0, lat, prAt, errAt, cntAt, addrAt, wdAt, wrAt);
        checkOutput("post rst wr latency", 32'(lat), 32'd1);
        applyIdle(1, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
